msf_encoder: RTL and testbench

Generates an MSF-format (60 kHz time signal) carrier-keying bit stream from BCD time-of-day fields, one 60-second frame per minute. It is the transmit-side counterpart of the MSF clock's decode and timekeeping chain, driving a carrier on/off enable for a test transmitter or a loopback into the receiver input. An internal prescaler, slot counter and second counter sequence the 100 ms slots. The block captures the time fields at each frame start and computes the four odd-parity bits.

---
 rtl/msf_encoder.sv | 152 +++++++++++++++
 tb/tb_msf_encoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/msf_encoder.sv
// MSF 60 kHz time-signal keying generator: sequences 100 ms slots and 60 s frames,
// keying the carrier from time fields captured at the start of every frame.
module msf_encoder #(
    parameter int TICKS_PER_SLOT = 1000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [7:0] year_i,
    input  logic [4:0] month_i,
    input  logic [5:0] day_i,
    input  logic [2:0] dow_i,
    input  logic [5:0] hour_i,
    input  logic [6:0] minute_i,
    input  logic       bst_i,
    input  logic       bst_warn_i,
    output logic       carrier_o,
    output logic [5:0] second_o,
    output logic       sec_strobe_o,
    output logic       frame_start_o
);

    localparam int PW = (TICKS_PER_SLOT > 2) ? $clog2(TICKS_PER_SLOT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SLOT - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    slot_q, slot_d;
    logic [5:0]    sec_q, sec_d;
    logic [34:0]   shadow_q, shadow_d;
    logic          bst_q, bst_d;
    logic          warn_q, warn_d;
    logic          carrier_q, carrier_d;
    logic          strobe_q, strobe_d;
    logic          fstart_q, fstart_d;
    logic          capture;
    logic          aBit, bBit, slotOff;
    logic [5:0]    dataIdx;

    // Counters advance to the position that will be shown after this edge.
    always_comb begin
        state_d  = state_q;
        presc_d  = '0;
        slot_d   = '0;
        sec_d    = '0;
        capture  = 1'b0;
        shadow_d = shadow_q;
        bst_d    = bst_q;
        warn_d   = warn_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            state_d = RUN;
            if (state_q == IDLE) begin
                capture = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
                slot_d  = slot_q;
                sec_d   = sec_q;
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    slot_d  = slot_q + 4'd1;
                    if (slot_q == 4'd9) begin
                        slot_d = 4'd0;
                        if (sec_q == 6'd59) begin
                            sec_d   = 6'd0;
                            capture = 1'b1;
                        end else begin
                            sec_d = sec_q + 6'd1;
                        end
                    end
                end
            end
            if (capture) begin
                shadow_d = {year_i, month_i, day_i, dow_i, hour_i, minute_i};
                bst_d    = bst_i;
                warn_d   = bst_warn_i;
            end
        end
    end

    // Shadow layout puts year MSB at bit 34 and minute LSB at bit 0, so sec 17..51 maps to bit 51-sec.
    always_comb begin
        aBit    = 1'b0;
        bBit    = 1'b0;
        dataIdx = 6'd51 - sec_d;
        if (sec_d >= 6'd17 && sec_d <= 6'd51) begin
            aBit = shadow_d[dataIdx];
        end else if (sec_d >= 6'd53 && sec_d <= 6'd58) begin
            aBit = 1'b1;
        end
        case (sec_d)
            6'd53:   bBit = warn_d;
            6'd54:   bBit = ~^shadow_d[34:27];
            6'd55:   bBit = ~^shadow_d[26:16];
            6'd56:   bBit = ~^shadow_d[15:13];
            6'd57:   bBit = ~^shadow_d[12:0];
            6'd58:   bBit = bst_d;
            default: bBit = 1'b0;
        endcase
        if (sec_d == 6'd0) begin
            slotOff = (slot_d < 4'd5);
        end else begin
            slotOff = (slot_d == 4'd0) || (slot_d == 4'd1 && aBit) || (slot_d == 4'd2 && bBit);
        end
    end

    always_comb begin
        carrier_d = 1'b1;
        strobe_d  = 1'b0;
        fstart_d  = 1'b0;
        if (state_d == RUN) begin
            carrier_d = ~slotOff;
            strobe_d  = (presc_d == '0) && (slot_d == 4'd0);
            fstart_d  = (presc_d == '0) && (slot_d == 4'd0) && (sec_d == 6'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            slot_q    <= '0;
            sec_q     <= '0;
            shadow_q  <= '0;
            bst_q     <= 1'b0;
            warn_q    <= 1'b0;
            carrier_q <= 1'b1;
            strobe_q  <= 1'b0;
            fstart_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            slot_q    <= slot_d;
            sec_q     <= sec_d;
            shadow_q  <= shadow_d;
            bst_q     <= bst_d;
            warn_q    <= warn_d;
            carrier_q <= carrier_d;
            strobe_q  <= strobe_d;
            fstart_q  <= fstart_d;
        end
    end

    assign carrier_o     = carrier_q;
    assign second_o      = sec_q;
    assign sec_strobe_o  = strobe_q;
    assign frame_start_o = fstart_q;

endmodule

// File: tb/tb_msf_encoder.sv
// Bench for msf_encoder: per-cycle expected outputs are queued when stimulus is driven
// and compared on every falling edge by a monitor.
module tb_msf_encoder;

    localparam int TPS       = 4;
    localparam int SEC_CYC   = 10 * TPS;
    localparam int FRAME_CYC = 60 * SEC_CYC;

    typedef struct packed {
        logic       carrier;
        logic [5:0] sec;
        logic       strobe;
        logic       fstart;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] year;
    logic [4:0] month;
    logic [5:0] day;
    logic [2:0] dow;
    logic [5:0] hour;
    logic [6:0] minute;
    logic       bst;
    logic       bstWarn;
    logic       carrier;
    logic [5:0] second;
    logic       secStrobe;
    logic       frameStart;

    exp_t expQ[$];
    exp_t monExp;
    int   fsTimes[$];
    int   checks = 0;
    int   failures = 0;
    int   cycleCount = 0;
    logic aBits[60];
    logic bBits[60];

    msf_encoder #(.TICKS_PER_SLOT(TPS)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .year_i       (year),
        .month_i      (month),
        .day_i        (day),
        .dow_i        (dow),
        .hour_i       (hour),
        .minute_i     (minute),
        .bst_i        (bst),
        .bst_warn_i   (bstWarn),
        .carrier_o    (carrier),
        .second_o     (second),
        .sec_strobe_o (secStrobe),
        .frame_start_o(frameStart)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic oddParity(input int lo, input int hi);
        int ones = 0;
        for (int i = lo; i <= hi; i++) if (aBits[i]) ones++;
        return (ones % 2) == 0;
    endfunction

    // Lays the current input fields out as the per-second A and B bit tables of one frame.
    task automatic buildFrame();
        int s = 17;
        for (int i = 0; i < 60; i++) begin
            aBits[i] = 1'b0;
            bBits[i] = 1'b0;
        end
        for (int i = 7; i >= 0; i--) begin aBits[s] = year[i];   s++; end
        for (int i = 4; i >= 0; i--) begin aBits[s] = month[i];  s++; end
        for (int i = 5; i >= 0; i--) begin aBits[s] = day[i];    s++; end
        for (int i = 2; i >= 0; i--) begin aBits[s] = dow[i];    s++; end
        for (int i = 5; i >= 0; i--) begin aBits[s] = hour[i];   s++; end
        for (int i = 6; i >= 0; i--) begin aBits[s] = minute[i]; s++; end
        for (int i = 53; i <= 58; i++) aBits[i] = 1'b1;
        bBits[53] = bstWarn;
        bBits[54] = oddParity(17, 24);
        bBits[55] = oddParity(25, 35);
        bBits[56] = oddParity(36, 38);
        bBits[57] = oddParity(39, 51);
        bBits[58] = bst;
    endtask

    task automatic pushFrame(input int j0, input int j1);
        exp_t e;
        int   sec;
        int   slot;
        for (int j = j0; j <= j1; j++) begin
            sec  = j / SEC_CYC;
            slot = (j % SEC_CYC) / TPS;
            if (sec == 0) e.carrier = (slot >= 5);
            else e.carrier = !((slot == 0) || (slot == 1 && aBits[sec]) || (slot == 2 && bBits[sec]));
            e.sec    = 6'(sec);
            e.strobe = ((j % SEC_CYC) == 0);
            e.fstart = (j == 0);
            expQ.push_back(e);
        end
    endtask

    task automatic pushIdle(input int n);
        exp_t e;
        e.carrier = 1'b1;
        e.sec     = 6'd0;
        e.strobe  = 1'b0;
        e.fstart  = 1'b0;
        for (int i = 0; i < n; i++) expQ.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        assert (expQ.size() == 0) else begin
            failures++;
            $error("[TB] FAIL drain_timeout observed=%0d pending expected=0", expQ.size());
            expQ.delete();
        end
    endtask

    always @(negedge clk) begin
        cycleCount++;
        if (frameStart === 1'b1) fsTimes.push_back(cycleCount);
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            checkOutput("carrier", 32'(carrier), 32'(monExp.carrier));
            checkOutput("second", 32'(second), 32'(monExp.sec));
            checkOutput("sec_strobe", 32'(secStrobe), 32'(monExp.strobe));
            checkOutput("frame_start", 32'(frameStart), 32'(monExp.fstart));
        end
    end

    // Frame 1 and 2 run back to back with a mid-frame minute change; frame 2 is aborted at sec 40 slot 1.
    task automatic applyStimulus();
        rst_n   = 1'b0;
        enable  = 1'b0;
        year    = 8'h24;
        month   = 5'h06;
        day     = 6'h15;
        dow     = 3'd4;
        hour    = 6'h12;
        minute  = 7'h35;
        bst     = 1'b1;
        bstWarn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_carrier", 32'(carrier), 32'd1);
        checkOutput("reset_second", 32'(second), 32'd0);
        checkOutput("reset_strobe", 32'(secStrobe), 32'd0);
        checkOutput("reset_fstart", 32'(frameStart), 32'd0);
        #1 rst_n = 1'b1;
        pushIdle(100);
        drain(150);

        @(negedge clk);
        #1 enable = 1'b1;
        buildFrame();
        pushFrame(0, FRAME_CYC - 1);

        repeat (1205) @(negedge clk);
        #1 minute = 7'h47;
        buildFrame();
        pushFrame(0, 40 * SEC_CYC + TPS);

        repeat (2800) @(negedge clk);
        #1 enable = 1'b0;
        pushIdle(1);
        @(negedge clk);
        #1 enable = 1'b1;
        buildFrame();
        pushFrame(0, FRAME_CYC - 1);
        pushFrame(0, 99);
        drain(2600);

        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_carrier", 32'(carrier), 32'd1);
        checkOutput("async_reset_second", 32'(second), 32'd0);
        checkOutput("async_reset_strobe", 32'(secStrobe), 32'd0);
        checkOutput("async_reset_fstart", 32'(frameStart), 32'd0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        applyStimulus();
        checkOutput("frame_start_count", 32'(fsTimes.size()), 32'd4);
        if (fsTimes.size() == 4) begin
            checkOutput("frame_spacing_1_2", 32'(fsTimes[1] - fsTimes[0]), 32'(FRAME_CYC));
            checkOutput("frame_spacing_abort", 32'(fsTimes[2] - fsTimes[1]), 32'(40 * SEC_CYC + TPS + 2));
            checkOutput("frame_spacing_3_4", 32'(fsTimes[3] - fsTimes[2]), 32'(FRAME_CYC));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
